ref_window_buffer: RTL and testbench
====================================

# ref_window_buffer

Parametrised, double-buffered successor to the reference-pixel SRAM in the motion-estimation datapath. Accepts packed pixel words from the frame-memory reader and assembles one full search window per bank (WIN_H rows × WIN_W pixels). It then streams the window row by row to the SAD array under a valid/ready handshake. With ping-pong enabled, the next window fills while the current one drains, so back-to-back blocks run without bubbles.

## Interface
- PIX_W, 8, bits per pixel
- IN_PIX, 8, pixels per input word
- BLK, 16, current-block edge in pixels
- SR, 4, search range; WIN_W = WIN_H = BLK + 2*SR − 1 (23 at defaults)
- Derived: WPR = ceil(WIN_W/IN_PIX) words per row (3); WPB = WPR*WIN_H words per bank (69)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ref_in  in  IN_PIX*PIX_W  packed pixels; pixel k at [PIX_W*k +: PIX_W], lower k = lower address
- ref_valid  in  1  ref_in valid
- read_en  out  1  buffer can accept a word; a word is accepted when read_en && ref_valid
- ref_out  out  WIN_W*PIX_W  one window row; pixel j at [PIX_W*j +: PIX_W]
- out_valid  out  1  ref_out holds a valid row
- out_ready  in  1  consumer accepts the row when out_valid && out_ready
- sram_ready  out  1  at least one bank is FULL or DRAINING
- next_block  out  1  one-cycle pulse on acceptance of the last row (row WIN_H−1) of a window

## Operation
- Two banks, each WIN_H × WIN_W pixels, each with state EMPTY → FILLING → FULL → DRAINING → EMPTY.
- Write side: wr_bank, word counter wc (0..WPR−1), row counter wr_row (0..WIN_H−1). An accepted word writes pixels k to row wr_row, columns wc*IN_PIX+k. Columns ≥ WIN_W are discarded: the last 1 pixel of word 2 at defaults.
- When word WPB−1 of a bank is accepted, that bank becomes FULL and wr_bank toggles.
- read_en = 1 iff bank wr_bank is EMPTY or FILLING.
- Read side: rd_bank, row counter rd_row. ref_out/out_valid form an output register. It loads row rd_row of bank rd_bank when that bank is FULL/DRAINING and (!out_valid || out_ready).
- The load of row WIN_H−1 returns the bank to EMPTY and toggles rd_bank.
- next_block asserts for one cycle on the handshake of the row WIN_H−1 that was loaded.
- Simultaneous fill-complete on one bank and last-row load on the other: both transitions apply in the same cycle with no priority conflict.

## Timing
- Reset values: read_en 0, out_valid 0, ref_out 0, sram_ready 0, next_block 0. All counters 0, both banks EMPTY, wr_bank = rd_bank = 0.
- read_en rises on the first clk edge after rst_n deasserts.
- Latency: out_valid rises on the edge after the bank's last word is accepted (1 cycle).
- With out_ready held at 1, rows issue one per cycle. Window-to-window transitions have no idle cycle if the next bank is already FULL.
- With out_valid = 1 and out_ready = 0, ref_out is held stable.
- rst_n asserted mid-fill or mid-drain: all state is lost immediately. Partially written rows are never output.
- Counter widths: $clog2 of each range, minimum 1 bit. Counters wrap to 0 at terminal count.

## Configuration
- REF_PINGPONG_EN defined: two banks, behaviour as above.
- REF_PINGPONG_EN undefined: a single bank. read_en drops after WPB words are accepted and rises again on the cycle after the next_block pulse. All other timing is unchanged.

## Test plan
- Reset: hold rst_n=0 with ref_valid=1 → read_en=0, out_valid=0, ref_out=0, next_block=0. Release → read_en=1 on the next edge.
- Fill/stream with defaults: bytes 0,1,2,… continuous, out_ready=1.
  - out_valid rises 1 cycle after word 68 is accepted.
  - Row 0 = bytes 0..22; byte 23 is dropped. Row 1 = bytes 24..46.
  - next_block pulses on the 23rd row.
- Backpressure: drop out_ready for 5 cycles at row 4 → ref_out stays equal to row 4 and rd_row does not advance. Resuming yields row 5.
- Ping-pong (macro on), continuous input, out_ready=0:
  - read_en stays high for exactly 138 accepted words, then goes low.
  - Raising out_ready restores read_en 1 cycle after the row-22 load of bank 0.
  - Rows from bank 1 follow bank 0 with no gap.
- Mid-operation reset: assert rst_n low after 40 words → all outputs reach reset values asynchronously. A fresh fill of 69 words then outputs only new data.
- Macro off: read_en=0 after word 68, through all 23 row handshakes. read_en=1 on the cycle after next_block.

Source files
------------

// File: rtl/ref_window_buffer_if.sv
// ref_window_buffer_if: pixel-word input and window-row output handshakes
// of the reference window buffer. The slave side belongs to the buffer.
interface ref_window_buffer_if #(
  parameter int PIX_W  = 8,
  parameter int IN_PIX = 8,
  parameter int WIN_W  = 23
);
  logic [IN_PIX*PIX_W-1:0] ref_in;
  logic                    ref_valid;
  logic                    read_en;
  logic [WIN_W*PIX_W-1:0]  ref_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sram_ready;
  logic                    next_block;

  modport master (
    output ref_in, ref_valid, out_ready,
    input  read_en, ref_out, out_valid, sram_ready, next_block
  );
  modport slave (
    input  ref_in, ref_valid, out_ready,
    output read_en, ref_out, out_valid, sram_ready, next_block
  );
endinterface

// File: rtl/ref_window_buffer.sv
// ref_window_buffer: assembles WIN_H x WIN_W reference windows from packed
// pixel words and streams them one row per handshake to the SAD array.
// Optional macro REF_PINGPONG_EN: adds a second bank so the next window
// fills while the current one drains. Without it a single bank refills only
// after the last row of the previous window has been accepted.
module ref_window_buffer #(
  parameter int PIX_W  = 8,
  parameter int IN_PIX = 8,
  parameter int BLK    = 16,
  parameter int SR     = 4
) (
  input logic                clk,
  input logic                rst_n,
  ref_window_buffer_if.slave bus
);
  localparam int WIN_W = BLK + 2*SR - 1;
  localparam int WIN_H = WIN_W;
  localparam int WPR   = (WIN_W + IN_PIX - 1) / IN_PIX;
`ifdef REF_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  localparam int NB  = PP ? 2 : 1;
  localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW  = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam int AW  = (NB*WIN_H > 1) ? $clog2(NB*WIN_H) : 1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  // Two state slots always exist; in single-bank builds slot 1 stays EMPTY
  // and both bank pointers stay at 0.
  bank_st_e               r_bst [2];
  bank_st_e               w_bst_nxt [2];
  logic                   r_started;
  logic                   r_wr_bank, r_rd_bank;
  logic                   r_ov, r_last;
  logic [WCW-1:0]         r_wc;
  logic [RW-1:0]          r_wr_row, r_rd_row;
  logic [WIN_W*PIX_W-1:0] r_ref_out;
  logic [PIX_W-1:0]       r_mem [NB*WIN_H][WIN_W];
  logic                   w_acc, w_wlast, w_ld, w_rlast, w_nb;
  logic [AW-1:0]          w_wa, w_ra;

  assign bus.read_en = r_started &&
                       (r_bst[r_wr_bank] == EMPTY || r_bst[r_wr_bank] == FILLING);
  assign w_acc   = bus.read_en && bus.ref_valid;
  assign w_wlast = (r_wc == WCW'(WPR-1)) && (r_wr_row == RW'(WIN_H-1));
  assign w_rlast = (r_rd_row == RW'(WIN_H-1));
  // Single bank: once the last row sits in the output register, further
  // loads wait until it is accepted and the bank has been released.
  assign w_ld    = (r_bst[r_rd_bank] == FULL || r_bst[r_rd_bank] == DRAINING) &&
                   (!r_ov || bus.out_ready) && (PP || !(r_ov && r_last));
  assign w_nb    = r_ov && bus.out_ready && r_last;
  assign w_wa    = AW'(int'(r_wr_bank) * WIN_H + int'(r_wr_row));
  assign w_ra    = AW'(int'(r_rd_bank) * WIN_H + int'(r_rd_row));

  assign bus.ref_out    = r_ref_out;
  assign bus.out_valid  = r_ov;
  assign bus.next_block = w_nb;
  assign bus.sram_ready = (r_bst[0] == FULL) || (r_bst[0] == DRAINING) ||
                          (r_bst[1] == FULL) || (r_bst[1] == DRAINING);

  // Per-bank lifecycle; write and read sides never touch the same bank in the
  // same state, so a fill-complete and a last-row load apply together.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bst_nxt[b] = r_bst[b];
      case (r_bst[b])
        EMPTY, FILLING:
          if (w_acc && r_wr_bank == 1'(b)) w_bst_nxt[b] = w_wlast ? FULL : FILLING;
        FULL, DRAINING:
          if (w_ld && r_rd_bank == 1'(b)) w_bst_nxt[b] = (w_rlast && PP) ? EMPTY : DRAINING;
          else if (!PP && w_nb)           w_bst_nxt[b] = EMPTY;
        default: ;
      endcase
    end
  end

  // Bank states and write-side counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bst     <= '{EMPTY, EMPTY};
      r_started <= 1'b0;
      r_wr_bank <= 1'b0;
      r_wc      <= '0;
      r_wr_row  <= '0;
    end else begin
      r_started <= 1'b1;
      r_bst     <= w_bst_nxt;
      if (w_acc) begin
        if (r_wc == WCW'(WPR-1)) begin
          r_wc     <= '0;
          r_wr_row <= (r_wr_row == RW'(WIN_H-1)) ? '0 : r_wr_row + 1'b1;
        end else begin
          r_wc <= r_wc + 1'b1;
        end
        if (w_wlast && PP) r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Pixel storage; columns past WIN_W in the last word of a row are dropped.
  always_ff @(posedge clk) begin
    if (w_acc)
      for (int c = 0; c < WIN_W; c++)
        if (r_wc == WCW'(c / IN_PIX))
          r_mem[w_wa][c] <= bus.ref_in[PIX_W*(c % IN_PIX) +: PIX_W];
  end

  // Output row register and read-side counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov      <= 1'b0;
      r_last    <= 1'b0;
      r_rd_row  <= '0;
      r_rd_bank <= 1'b0;
      r_ref_out <= '0;
    end else if (w_ld) begin
      r_ov     <= 1'b1;
      r_last   <= w_rlast;
      for (int j = 0; j < WIN_W; j++)
        r_ref_out[PIX_W*j +: PIX_W] <= r_mem[w_ra][j];
      r_rd_row <= w_rlast ? '0 : r_rd_row + 1'b1;
      if (w_rlast && PP) r_rd_bank <= ~r_rd_bank;
    end else if (bus.out_ready) begin
      r_ov   <= 1'b0;
      r_last <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ref_window_buffer.sv
// tb_ref_window_buffer: directed checks of reset, fill/stream, backpressure,
// mid-operation reset and (with REF_PINGPONG_EN) bank overlap.
module tb_ref_window_buffer;
  localparam int PIX_W = 8, IN_PIX = 8, WIN_W = 23, WPB = 69;
  localparam int OW = WIN_W*PIX_W;
`ifdef REF_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ref_window_buffer_if #(.PIX_W(PIX_W), .IN_PIX(IN_PIX), .WIN_W(WIN_W)) bus();
  ref_window_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word n carries bytes 8n..8n+7, lowest byte in pixel 0.
  function automatic logic [IN_PIX*PIX_W-1:0] word(input int n);
    logic [IN_PIX*PIX_W-1:0] w;
    for (int k = 0; k < IN_PIX; k++) w[PIX_W*k +: PIX_W] = 8'(8*n + k);
    return w;
  endfunction

  // Row r of a window whose first word carries byte off: bytes off+24r+c.
  function automatic logic [OW-1:0] exp_row(input int off, input int r);
    logic [OW-1:0] v;
    for (int c = 0; c < WIN_W; c++) v[PIX_W*c +: PIX_W] = 8'(off + 24*r + c);
    return v;
  endfunction

  // Present words first.. until n are accepted, bounded by a cycle budget.
  task automatic feed(input int first, input int n, input string tag);
    int cnt = 0;
    int cyc = 0;
    logic acc;
    bus.ref_valid = 1'b1;
    while (cnt < n && cyc < 400) begin
      bus.ref_in = word(first + cnt);
      acc = bus.read_en;
      tick();
      if (acc) cnt++;
      cyc++;
    end
    bus.ref_valid = 1'b0;
    chk(tag, OW'(cnt), OW'(n));
  endtask

  initial begin
    bus.ref_in    = word(0);
    bus.ref_valid = 1'b1;
    bus.out_ready = 1'b0;

    // Reset held with input offered.
    repeat (3) tick();
    chk("rst_read_en",    OW'(bus.read_en),    '0);
    chk("rst_out_valid",  OW'(bus.out_valid),  '0);
    chk("rst_ref_out",    bus.ref_out,         '0);
    chk("rst_next_block", OW'(bus.next_block), '0);
    chk("rst_sram_ready", OW'(bus.sram_ready), '0);
    rst_n = 1'b1;
    #1;
    chk("rel_read_en_pre", OW'(bus.read_en), '0);
    tick();
    chk("rel_read_en_edge", OW'(bus.read_en), OW'(1));

    // Fill one window from bytes 0,1,2,... and stream it.
    bus.out_ready = 1'b1;
    feed(0, WPB, "fill0_count");
    chk("fill0_ov_lat0",   OW'(bus.out_valid),  '0);
    chk("fill0_read_en",   OW'(bus.read_en),    OW'(PP));
    chk("fill0_sram_rdy",  OW'(bus.sram_ready), OW'(1));
    tick();
    chk("row0_valid", OW'(bus.out_valid), OW'(1));
    chk("row0_data",  bus.ref_out, exp_row(0, 0));
    tick();
    chk("row1_data",  bus.ref_out, exp_row(0, 1));
    repeat (3) tick();
    chk("row4_data",  bus.ref_out, exp_row(0, 4));

    // Backpressure holds row 4.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_row4", bus.ref_out, exp_row(0, 4));
    end
    chk("bp_valid", OW'(bus.out_valid), OW'(1));
    bus.out_ready = 1'b1;
    tick();
    chk("bp_resume_row5", bus.ref_out, exp_row(0, 5));

    for (int r = 6; r <= 22; r++) begin
      tick();
      chk("stream_row", bus.ref_out, exp_row(0, r));
      if (r == 21) chk("nb_row21", OW'(bus.next_block), '0);
    end
    chk("nb_row22",      OW'(bus.next_block), OW'(1));
    chk("row22_read_en", OW'(bus.read_en),    OW'(PP));
    tick();
    chk("post_nb_pulse",   OW'(bus.next_block), '0);
    chk("post_nb_valid",   OW'(bus.out_valid),  '0);
    chk("post_nb_read_en", OW'(bus.read_en),    OW'(1));

    // Reset mid-fill: outputs drop asynchronously.
    feed(1000, 40, "midfill_count");
    #3;
    rst_n = 1'b0;
    #1;
    chk("midfill_rst_read_en",    OW'(bus.read_en),    '0);
    chk("midfill_rst_sram_ready", OW'(bus.sram_ready), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("midfill_rel_read_en", OW'(bus.read_en), OW'(1));

    // Fresh window after reset outputs only new data.
    feed(2000, WPB, "fresh_count");
    tick();
    chk("fresh_row0", bus.ref_out, exp_row(8*2000, 0));
    tick();
    tick();
    chk("fresh_row2", bus.ref_out, exp_row(8*2000, 2));

    // Reset mid-drain.
    #3;
    rst_n = 1'b0;
    #1;
    chk("middrain_valid",      OW'(bus.out_valid),  '0);
    chk("middrain_ref_out",    bus.ref_out,         '0);
    chk("middrain_next_block", OW'(bus.next_block), '0);
    chk("middrain_sram_ready", OW'(bus.sram_ready), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

`ifdef REF_PINGPONG_EN
    // Both banks fill under full backpressure, then drain back to back.
    begin
      int cnt = 0;
      int cyc = 0;
      logic acc;
      bus.out_ready = 1'b0;
      bus.ref_valid = 1'b1;
      while (cyc < 400) begin
        bus.ref_in = word(3000 + cnt);
        acc = bus.read_en;
        tick();
        if (acc) cnt++;
        cyc++;
        if (!bus.read_en) break;
      end
      chk("pp_words_accepted", OW'(cnt), OW'(2*WPB));
      chk("pp_row0_bank0", bus.ref_out, exp_row(8*3000, 0));
      bus.ref_in = word(3000 + cnt);
      bus.out_ready = 1'b1;
      for (int r = 1; r <= 22; r++) begin
        tick();
        if (r == 21) chk("pp_read_en_row21", OW'(bus.read_en), '0);
      end
      chk("pp_row22_bank0",   bus.ref_out,      exp_row(8*3000, 22));
      chk("pp_read_en_row22", OW'(bus.read_en), OW'(1));
      tick();
      bus.ref_valid = 1'b0;
      chk("pp_bank1_nogap_valid", OW'(bus.out_valid), OW'(1));
      chk("pp_bank1_row0", bus.ref_out, exp_row(8*(3000 + WPB), 0));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
